// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encodings and
// register constants.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_LU_STALL = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard request / pipeline control bundle between the datapath (master) and
// the hazard sequencer (slave).
interface pipeline_hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             Jump;
  logic             BNE;
  logic             JR;
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic             EX_MemoryRead;
  logic [4:0]       EX_Rt;
  logic             MemoryBusy;
  logic             ClearCounters;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFFlush;
  logic             IDFlush;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output Jump, BNE, JR, ID_Rs, ID_Rt, ID_UsesRt, EX_MemoryRead, EX_Rt,
           MemoryBusy, ClearCounters,
    input  PCWrite, IFIDWrite, IFFlush, IDFlush, StallCount, FlushCount
  );

  modport slave (
    input  Jump, BNE, JR, ID_Rs, ID_Rt, ID_UsesRt, EX_MemoryRead, EX_Rt,
           MemoryBusy, ClearCounters,
    output PCWrite, IFIDWrite, IFFlush, IDFlush, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment
// and the count holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates memory wait,
// redirects and load-use hazards into PC/IF-ID enables and flush strobes.
//
//  state       | meaning
//  ------------+-----------------------------------------------------------
//  ST_RUN      | normal issue; redirects and load-use hazards evaluated
//  ST_FLUSH    | extra cycles of wrong-path squash after a redirect
//  ST_LU_STALL | extra bubble cycles for a load-use hazard
//  ST_MEM_WAIT | pipeline frozen on data memory; behaves as RUN once ready
module pipeline_hazard_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES      = 1,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input logic                  Clock,
  input logic                  Reset,
  pipeline_hazard_sequencer_if.slave hz
);

  localparam int MAX_SEQ = max2(FLUSH_CYCLES, LOAD_STALL_CYCLES);
  localparam int RW      = $clog2(MAX_SEQ + 1);

  state_e        state_q, state_d;
  logic [RW-1:0] remain_q, remain_d;

  logic redirect, load_use;
  logic pc_we, ifid_we, if_flush, id_flush;
  logic stall_inc, flush_inc;

  assign redirect = hz.Jump | hz.BNE | hz.JR;
  assign load_use = hz.EX_MemoryRead && (hz.EX_Rt != REG_ZERO) &&
                    ((hz.EX_Rt == hz.ID_Rs) || (hz.ID_UsesRt && (hz.EX_Rt == hz.ID_Rt)));

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (hz.MemoryBusy) begin
      // Freeze everything; the held redirect re-presents once memory is ready.
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      state_d  = ST_MEM_WAIT;
      remain_d = '0;
    end else begin
      unique case (state_q)
        ST_FLUSH: begin
          if_flush = 1'b1;
          id_flush = 1'b1;
          remain_d = remain_q - RW'(1);
          if (remain_q == RW'(1)) state_d = ST_RUN;
        end
        ST_LU_STALL: begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          id_flush  = 1'b1;
          stall_inc = 1'b1;
          remain_d  = remain_q - RW'(1);
          if (remain_q == RW'(1)) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          if (redirect) begin
            if_flush  = 1'b1;
            id_flush  = hz.BNE | hz.JR;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d  = ST_FLUSH;
              remain_d = RW'(FLUSH_CYCLES - 1);
            end
          end else if (load_use) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            id_flush  = 1'b1;
            stall_inc = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d  = ST_LU_STALL;
              remain_d = RW'(LOAD_STALL_CYCLES - 1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= ST_RUN;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  assign hz.PCWrite   = Reset & pc_we;
  assign hz.IFIDWrite = Reset & ifid_we;
  assign hz.IFFlush   = ~Reset | if_flush;
  assign hz.IDFlush   = ~Reset | id_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .inc_i   (stall_inc),
    .clr_i   (hz.ClearCounters),
    .count_o (hz.StallCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .inc_i   (flush_inc),
    .clr_i   (hz.ClearCounters),
    .count_o (hz.FlushCount)
  );

endmodule
